// File: rtl/ff_response_checker_pkg.sv
// Shared types for the flip-flop response checker: FSM encoding, reference
// model mode selectors and small state-decode helpers.
package ff_check_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    FAIL  = 3'd4
  } state_t;

  localparam int MODE_SYNC  = 0;
  localparam int MODE_ASYNC = 1;

  function automatic logic is_busy(state_t s);
    return (s == PRIME) || (s == CHECK);
  endfunction

  function automatic logic is_done(state_t s);
    return (s == DONE) || (s == FAIL);
  endfunction

endpackage

// File: rtl/ff_response_checker_if.sv
// Observation bundle between the test harness and the checker.
interface ff_response_checker_if;
  // start is a one-cycle request pulse with no ready: it is accepted only in
  // IDLE, DONE or FAIL and silently dropped while a run is in progress.
  // D_obs/RSTN_obs/Q_obs are sampled every clk edge with no qualifier.
  logic start;
  logic D_obs;
  logic RSTN_obs;
  logic Q_obs;

  modport master (output start, output D_obs, output RSTN_obs, output Q_obs);
  modport slave  (input  start, input  D_obs, input  RSTN_obs, input  Q_obs);
endinterface

// File: rtl/ff_response_checker_ref_model.sv
// Cycle-accurate reference D flip-flop. exp is the value the DUT's Q should
// show in the current cycle.
module ff_ref_model
  import ff_check_pkg::*;
#(
  parameter int ASYNC_MODE = MODE_SYNC
) (
  input  logic clk,
  input  logic RST,
  input  logic en,
  input  logic D_obs,
  input  logic RSTN_obs,
  output logic exp
);

  logic exp_q;

  always_ff @(posedge clk) begin
    if (RST) begin
      exp_q <= 1'b0;
    end else if (en) begin
      exp_q <= RSTN_obs ? D_obs : 1'b0;
    end
  end

  // An async-reset DUT clears Q as soon as RSTN drops, before the next edge.
  generate
    if (ASYNC_MODE == MODE_ASYNC) begin : g_async
      assign exp = RSTN_obs & exp_q;
    end else begin : g_sync
      assign exp = exp_q;
    end
  endgenerate

endmodule

// File: rtl/ff_response_checker.sv
// Run controller for the flip-flop checker: sequences a run, compares Q
// against the reference model and keeps check/error counters.
module ff_response_checker
  import ff_check_pkg::*;
#(
  parameter int ASYNC_MODE   = 0,
  parameter int NUM_CHECKS   = 32,
  parameter int CNT_W        = 8,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic                 clk,
  input  logic                 RST,
  ff_response_checker_if.slave obs,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 mismatch,
  output logic [CNT_W-1:0]     check_count,
  output logic [CNT_W-1:0]     err_count,
  output logic [2:0]           state_dbg
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHECKS - 1);

  state_t state, state_nx;
  logic   en;
  logic   clr;
  logic   exp_v;
  logic   miss;
  logic   last;

  ff_ref_model #(
    .ASYNC_MODE(ASYNC_MODE)
  ) u_ref (
    .clk      (clk),
    .RST      (RST),
    .en       (en),
    .D_obs    (obs.D_obs),
    .RSTN_obs (obs.RSTN_obs),
    .exp      (exp_v)
  );

  assign miss = (state == CHECK) && (obs.Q_obs != exp_v);
  assign last = (check_count == LAST_CNT);

  always_comb begin
    state_nx = state;
    en       = 1'b0;
    clr      = 1'b0;
    case (state)
      IDLE: begin
        if (obs.start) begin
          state_nx = PRIME;
          clr      = 1'b1;
        end
      end
      PRIME: begin
        en       = 1'b1;
        state_nx = CHECK;
      end
      CHECK: begin
        en = 1'b1;
        if ((STOP_ON_FAIL != 0) && miss) begin
          state_nx = FAIL;
        end else if (last) begin
          state_nx = DONE;
        end
      end
      DONE, FAIL: begin
        if (obs.start) begin
          state_nx = PRIME;
          clr      = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state       <= IDLE;
      mismatch    <= 1'b0;
      check_count <= '0;
      err_count   <= '0;
    end else begin
      state    <= state_nx;
      mismatch <= miss;
      if (clr) begin
        check_count <= '0;
        err_count   <= '0;
      end else if (state == CHECK) begin
        check_count <= check_count + 1'b1;
        if (miss && (err_count != '1)) begin
          err_count <= err_count + 1'b1;
        end
      end
    end
  end

  assign busy      = is_busy(state);
  assign done      = is_done(state);
  assign pass      = (state == DONE) && (err_count == '0);
  assign state_dbg = state;

endmodule

// File: tb/tb_ff_response_checker.sv
// Directed bench for ff_response_checker: five checker configurations watch
// a behavioural sync and async DFF; results are scoreboarded by a monitor.
module tb_ff_response_checker;
  import ff_check_pkg::*;

  localparam int NI = 5;
  localparam int P_ASYNC [NI] = '{MODE_SYNC, MODE_ASYNC, MODE_SYNC, MODE_SYNC, MODE_SYNC};
  localparam int P_NUM   [NI] = '{8, 8, 32, 7, 1};
  localparam int P_CNTW  [NI] = '{8, 8, 8, 3, 8};
  localparam int P_STOP  [NI] = '{0, 0, 1, 0, 1};

  logic clk = 1'b0;
  logic rst;
  logic d;
  logic rstn;
  logic q_s;
  logic q_a;
  logic [NI-1:0] start_v;
  logic [NI-1:0] flip;

  logic [NI-1:0] busy_v, done_v, pass_v, mm_v;
  logic [7:0]    cc_v [NI];
  logic [7:0]    ec_v [NI];
  logic [2:0]    st_v [NI];

  // result entry: {idx[2:0], state[2:0], pass, cc[7:0], ec[7:0], busy_cycles[7:0]}
  logic [30:0] exp_q [$];
  // mismatch entry: {idx[2:0], cc[7:0]}
  logic [10:0] mm_q [$];

  int total = 0;
  int bad   = 0;
  logic req_zero    = 1'b0;
  logic req_timeout = 1'b0;
  logic req_final   = 1'b0;

  always #5 clk = ~clk;

  // behavioural DUTs
  always @(posedge clk) q_s <= rstn ? d : 1'b0;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) q_a <= 1'b0;
    else       q_a <= d;
  end

  generate
    for (genvar g = 0; g < NI; g++) begin : g_chk
      localparam int W = P_CNTW[g];
      logic [W-1:0] cc, ec;
      logic bsy, dn, ps, mm;
      ff_response_checker_if ifc ();

      assign ifc.start    = start_v[g];
      assign ifc.D_obs    = d;
      assign ifc.RSTN_obs = rstn;
      assign ifc.Q_obs    = ((P_ASYNC[g] == MODE_ASYNC) ? q_a : q_s) ^ flip[g];

      ff_response_checker #(
        .ASYNC_MODE   (P_ASYNC[g]),
        .NUM_CHECKS   (P_NUM[g]),
        .CNT_W        (W),
        .STOP_ON_FAIL (P_STOP[g])
      ) dut (
        .clk         (clk),
        .RST         (rst),
        .obs         (ifc),
        .busy        (bsy),
        .done        (dn),
        .pass        (ps),
        .mismatch    (mm),
        .check_count (cc),
        .err_count   (ec),
        .state_dbg   (st_v[g])
      );

      assign busy_v[g] = bsy;
      assign done_v[g] = dn;
      assign pass_v[g] = ps;
      assign mm_v[g]   = mm;
      assign cc_v[g]   = 8'(cc);
      assign ec_v[g]   = 8'(ec);
    end
  endgenerate

  // ---------------- monitor / scoreboard ----------------
  logic [NI-1:0] done_p = '0;
  int bcnt [NI] = '{0, 0, 0, 0, 0};

  always @(negedge clk) begin
    logic [30:0] got, want;
    logic [10:0] mgot, mwant;
    logic [22:0] zgot;
    for (int i = 0; i < NI; i++) begin
      if (rst) bcnt[i] = 0;
      else if (busy_v[i]) bcnt[i] = bcnt[i] + 1;

      if (mm_v[i]) begin
        mgot = {3'(i), cc_v[i]};
        total++;
        if (mm_q.size() == 0) begin
          bad++;
          $display("FAIL mismatch_pulse inst=%0d cc=%0d got unexpected pulse, required none", i, cc_v[i]);
        end else begin
          mwant = mm_q.pop_front();
          if (mgot !== mwant) begin
            bad++;
            $display("FAIL mismatch_pulse got inst=%0d cc=%0d required inst=%0d cc=%0d",
                     mgot[10:8], mgot[7:0], mwant[10:8], mwant[7:0]);
          end
        end
      end

      if (done_v[i] && !done_p[i]) begin
        got = {3'(i), st_v[i], pass_v[i], cc_v[i], ec_v[i], 8'(bcnt[i])};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL result inst=%0d got unexpected done, required none", i);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            bad++;
            $display("FAIL result got inst=%0d st=%0d pass=%0b cc=%0d ec=%0d busy=%0d required inst=%0d st=%0d pass=%0b cc=%0d ec=%0d busy=%0d",
                     got[30:28], got[27:25], got[24], got[23:16], got[15:8], got[7:0],
                     want[30:28], want[27:25], want[24], want[23:16], want[15:8], want[7:0]);
          end
        end
        bcnt[i] = 0;
      end
      done_p[i] = done_v[i];

      if (req_zero) begin
        zgot = {busy_v[i], done_v[i], pass_v[i], mm_v[i], cc_v[i], ec_v[i], st_v[i]};
        total++;
        if (zgot !== '0) begin
          bad++;
          $display("FAIL idle_outputs inst=%0d got busy=%0b done=%0b pass=%0b mm=%0b cc=%0d ec=%0d st=%0d required all 0",
                   i, busy_v[i], done_v[i], pass_v[i], mm_v[i], cc_v[i], ec_v[i], st_v[i]);
        end
      end
    end

    if (req_timeout) begin
      total++;
      bad++;
      $display("FAIL run_timeout got no done within budget, required done");
    end

    if (req_final) begin
      total += 2;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL result_queue got %0d pending, required 0", exp_q.size());
      end
      if (mm_q.size() != 0) begin
        bad++;
        $display("FAIL mismatch_queue got %0d pending, required 0", mm_q.size());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_res(input int idx, input state_t st, input logic ps,
                          input int cc, input int ec, input int bc);
    exp_q.push_back({3'(idx), st, ps, 8'(cc), 8'(ec), 8'(bc)});
  endtask

  task automatic push_mm(input int idx, input int cc);
    mm_q.push_back({3'(idx), 8'(cc)});
  endtask

  task automatic check_zero();
    req_zero = 1'b1;
    tick();
    req_zero = 1'b0;
  endtask

  // c = 0 is the PRIME edge, c = k is compare k. dmode: 0 -> D=0, 1 -> D
  // alternates, 2 -> D=1. abort_c/restart_c < 0 disables those events.
  task automatic run(input int idx, input logic [63:0] flip_m, input logic [63:0] rlow_m,
                     input int dmode, input int abort_c, input int restart_c);
    logic fin;
    fin = 1'b0;
    start_v[idx] = 1'b1;
    tick();
    start_v[idx] = 1'b0;
    for (int c = 0; c <= P_NUM[idx] + 4; c++) begin
      d = (dmode == 0) ? 1'b0 : (dmode == 1) ? ((c % 2) == 1) : 1'b1;
      rstn = !rlow_m[c];
      flip[idx] = flip_m[c];
      start_v[idx] = (c == restart_c);
      if (c == abort_c) rst = 1'b1;
      tick();
      start_v[idx] = 1'b0;
      flip[idx] = 1'b0;
      rstn = 1'b1;
      if (c == abort_c) begin
        rst = 1'b0;
        check_zero();
        return;
      end
      if (done_v[idx]) begin
        fin = 1'b1;
        break;
      end
    end
    if (!fin) begin
      req_timeout = 1'b1;
      tick();
      req_timeout = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; d = 1'b0; rstn = 1'b1; start_v = '0; flip = '0;
    repeat (3) tick();
    check_zero();
    rst = 1'b0;
    tick();

    // sync, matching DUT, alternating D
    push_res(0, DONE, 1'b1, 8, 0, 9);
    run(0, 64'h0, 64'h0, 1, -1, -1);

    // Q forced high on compares 3 and 6 while exp is 0
    push_mm(0, 3); push_mm(0, 6);
    push_res(0, DONE, 1'b0, 8, 2, 9);
    run(0, 64'h48, 64'h0, 0, -1, -1);

    // mismatch on the last compare without stop-on-fail
    push_mm(0, 8);
    push_res(0, DONE, 1'b0, 8, 1, 9);
    run(0, 64'h100, 64'h0, 0, -1, -1);

    // async: RSTN dropped mid-cycle while exp_q = 1
    push_res(1, DONE, 1'b1, 8, 0, 9);
    run(1, 64'h0, 64'h2, 2, -1, -1);
    push_mm(1, 1);
    push_res(1, DONE, 1'b0, 8, 1, 9);
    run(1, 64'h2, 64'h2, 2, -1, -1);

    // stop on first mismatch at compare 4 of 32
    push_mm(2, 4);
    push_res(2, FAIL, 1'b0, 4, 1, 5);
    run(2, 64'h10, 64'h0, 1, -1, -1);

    // RST at compare 5, then a clean full run
    run(2, 64'h0, 64'h0, 1, 5, -1);
    push_res(2, DONE, 1'b1, 32, 0, 33);
    run(2, 64'h0, 64'h0, 1, -1, -1);

    // CNT_W = 3, constant mismatch, start while busy is ignored
    for (int k = 1; k <= 7; k++) push_mm(3, k);
    push_res(3, DONE, 1'b0, 7, 7, 8);
    run(3, {64{1'b1}}, 64'h0, 1, -1, 3);
    push_res(3, DONE, 1'b1, 7, 0, 8);
    run(3, 64'h0, 64'h0, 1, -1, -1);

    // NUM_CHECKS = 1, then a last-compare mismatch with stop-on-fail
    push_res(4, DONE, 1'b1, 1, 0, 2);
    run(4, 64'h0, 64'h0, 1, -1, -1);
    push_mm(4, 1);
    push_res(4, FAIL, 1'b0, 1, 1, 2);
    run(4, 64'h2, 64'h0, 1, -1, -1);

    repeat (3) tick();
    req_final = 1'b1;
    tick();
    req_final = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
